// File: rtl/traffic_scheduler_if.sv
// Control and strobe bundle between the level logic, the scheduler and the lane movers.
// The master side drives run/level controls. The slave side is the scheduler, which returns steps, period and state.
interface traffic_scheduler_if #(
    parameter int NUM_LANES = 4
);
    logic                 i_run;
    logic [6:0]           i_level;
    logic                 i_level_load;
    logic [NUM_LANES-1:0] o_step;
    logic [24:0]          o_period;
    logic [1:0]           o_state;

    modport master (
        output i_run, i_level, i_level_load,
        input  o_step, o_period, o_state
    );

    modport slave (
        input  i_run, i_level, i_level_load,
        output o_step, o_period, o_state
    );
endinterface

// File: rtl/traffic_scheduler.sv
// Shared time base for the traffic lanes. It maps the level to a step period and runs one base prescaler.
// Per-lane dividers turn base ticks into one-cycle lane step strobes, under run/pause control.
module traffic_scheduler #(
    parameter int                   NUM_LANES   = 4,
    parameter logic [24:0]          BASE_PERIOD = 25'd1000,
    parameter logic [24:0]          PERIOD_STEP = 25'd50,
    parameter logic [24:0]          MIN_PERIOD  = 25'd100,
    parameter logic [4*NUM_LANES-1:0] LANE_DIVS = 16'h4321
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    traffic_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_RUN   = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    state_t               r_state;
    logic [24:0]          r_period;
    logic [24:0]          r_base_cnt;
    logic [3:0]           r_lane_cnt [NUM_LANES];
    logic [NUM_LANES-1:0] r_step;

    state_t               w_next_state;
    logic                 w_run_cycle;
    logic                 w_tick;
    logic [31:0]          w_lvl;
    logic [31:0]          w_red;
    logic [24:0]          w_new_period;

    // A zero divisor nibble behaves as divide-by-one.
    function automatic logic [3:0] lane_div(input int k);
        logic [3:0] d;
        d = LANE_DIVS[4*k +: 4];
        return (d == 4'd0) ? 4'd1 : d;
    endfunction

    // The reduction is computed at 32 bits and clamped before subtracting, so a high level cannot wrap the period.
    always_comb begin
        w_lvl = (bus.i_level == 7'd0) ? 32'd1 : {25'd0, bus.i_level};
        w_red = (w_lvl - 32'd1) * {7'd0, PERIOD_STEP};
        if (w_red > {7'd0, BASE_PERIOD - MIN_PERIOD})
            w_new_period = MIN_PERIOD;
        else
            w_new_period = BASE_PERIOD - w_red[24:0];
    end

    // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_run_cycle  = 1'b0;
        w_tick       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_run)
                    w_next_state = S_LOAD;
            end
            S_LOAD: begin
                w_next_state = bus.i_run ? S_RUN : S_PAUSE;
            end
            S_RUN: begin
                // A reload request drops any tick due this cycle, so the old and new periods never mix.
                if (bus.i_level_load) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_run_cycle = 1'b1;
                    w_tick      = (r_base_cnt == 25'd0);
                    if (!bus.i_run)
                        w_next_state = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (bus.i_level_load)
                    w_next_state = S_LOAD;
                else if (bus.i_run)
                    w_next_state = S_RUN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values and no evaluation-order race can occur.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state    <= S_IDLE;
            r_period   <= BASE_PERIOD;
            r_base_cnt <= BASE_PERIOD - 25'd1;
            r_step     <= '0;
            // NOTE: the lane counter array is small and its phase matters after reset, so each entry is reset explicitly rather than left as RAM.
            for (int k = 0; k < NUM_LANES; k++)
                r_lane_cnt[k] <= lane_div(k) - 4'd1;
        end else begin
            r_state <= w_next_state;
            r_step  <= '0;

            if (r_state == S_LOAD) begin
                r_period   <= w_new_period;
                r_base_cnt <= w_new_period - 25'd1;
            end else if (w_run_cycle) begin
                r_base_cnt <= w_tick ? (r_period - 25'd1) : (r_base_cnt - 25'd1);
            end

            if (w_tick) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (r_lane_cnt[k] == 4'd0) begin
                        r_step[k]     <= 1'b1;
                        r_lane_cnt[k] <= lane_div(k) - 4'd1;
                    end else begin
                        r_lane_cnt[k] <= r_lane_cnt[k] - 4'd1;
                    end
                end
            end
        end
    end

    assign bus.o_step   = r_step;
    assign bus.o_period = r_period;
    assign bus.o_state  = r_state;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Bench for traffic_scheduler. Two instances (divisors 4321 and 0001) share the stimulus.
// A reference model queues the expected outputs each cycle, and a monitor pops and compares them.
module tb_traffic_scheduler;

    localparam int          BASE   = 20;
    localparam int          STEP   = 4;
    localparam int          MINP   = 8;
    localparam logic [15:0] DIVS_A = 16'h4321;
    localparam logic [15:0] DIVS_B = 16'h0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_scheduler_if #(.NUM_LANES(4)) bus_a ();
    traffic_scheduler_if #(.NUM_LANES(4)) bus_b ();

    traffic_scheduler #(
        .NUM_LANES(4), .BASE_PERIOD(25'(BASE)), .PERIOD_STEP(25'(STEP)),
        .MIN_PERIOD(25'(MINP)), .LANE_DIVS(DIVS_A)
    ) dut_a (
        .i_Clk(clk), .i_Rst(rst), .bus(bus_a)
    );

    traffic_scheduler #(
        .NUM_LANES(4), .BASE_PERIOD(25'(BASE)), .PERIOD_STEP(25'(STEP)),
        .MIN_PERIOD(25'(MINP)), .LANE_DIVS(DIVS_B)
    ) dut_b (
        .i_Clk(clk), .i_Rst(rst), .bus(bus_b)
    );

    typedef enum int {M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3} mstate_e;

    typedef struct packed {
        logic [3:0]  step_a;
        logic [3:0]  step_b;
        logic [24:0] period;
        logic [1:0]  state;
    } exp_t;

    exp_t    sb_q[$];
    int      n_checks = 0;
    int      n_errors = 0;

    // Reference model: phase = run cycles since the last tick, ticks = base ticks since reset.
    mstate_e m_state  = M_IDLE;
    int      m_period = BASE;
    int      m_phase  = 0;
    int      m_ticks  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int ref_period(input int level);
        int lvl;
        int red;
        lvl = (level == 0) ? 1 : level;
        red = (lvl - 1) * STEP;
        return (red > BASE - MINP) ? MINP : BASE - red;
    endfunction

    // Lane k strobes on every tick number that is a multiple of its divisor.
    function automatic logic [3:0] ref_strobes(input logic [15:0] divs, input int ticks);
        logic [3:0] s;
        int d;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            d = int'((divs >> (4 * k)) & 16'hF);
            if (d == 0) d = 1;
            s[k] = ((ticks % d) == 0);
        end
        return s;
    endfunction

    task automatic model_step(input logic r, input logic run, input int lvl, input logic ld);
        exp_t e;
        e.step_a = '0;
        e.step_b = '0;
        if (r) begin
            m_state = M_IDLE; m_period = BASE; m_phase = 0; m_ticks = 0;
        end else begin
            case (m_state)
                M_IDLE:  if (run) m_state = M_LOAD;
                M_LOAD: begin
                    m_period = ref_period(lvl);
                    m_phase  = 0;
                    m_state  = run ? M_RUN : M_PAUSE;
                end
                M_RUN: begin
                    if (ld) begin
                        m_state = M_LOAD;
                    end else begin
                        m_phase++;
                        if (m_phase == m_period) begin
                            m_phase  = 0;
                            m_ticks++;
                            e.step_a = ref_strobes(DIVS_A, m_ticks);
                            e.step_b = ref_strobes(DIVS_B, m_ticks);
                        end
                        if (!run) m_state = M_PAUSE;
                    end
                end
                M_PAUSE: begin
                    if (ld)       m_state = M_LOAD;
                    else if (run) m_state = M_RUN;
                end
                default: m_state = M_IDLE;
            endcase
        end
        e.period = 25'(m_period);
        e.state  = 2'(m_state);
        sb_q.push_back(e);
    endtask

    // Apply one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic cycle(input logic r, input logic run, input int lvl, input logic ld);
        @(negedge clk);
        rst                = r;
        bus_a.i_run        = run;
        bus_a.i_level      = 7'(lvl);
        bus_a.i_level_load = ld;
        bus_b.i_run        = run;
        bus_b.i_level      = 7'(lvl);
        bus_b.i_level_load = ld;
        model_step(r, run, lvl, ld);
    endtask

    // Monitor: the DUT presents outputs every cycle; compare one queued expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("step_a", 64'(bus_a.o_step), 64'(e.step_a));
                check("step_b", 64'(bus_b.o_step), 64'(e.step_b));
                check("period_state",
                      64'({bus_a.o_period, bus_a.o_state, bus_b.o_period, bus_b.o_state}),
                      64'({e.period, e.state, e.period, e.state}));
            end
        end
    end

    initial begin
        int lv_tab [4] = '{3, 0, 10, 127};
        int p_tab  [4] = '{12, 20, 8, 8};
        int lvl;
        int r;
        logic run_r;
        logic ld_r;
        logic rst_r;

        bus_a.i_run = 1'b0; bus_a.i_level = 7'd1; bus_a.i_level_load = 1'b0;
        bus_b.i_run = 1'b0; bus_b.i_level = 7'd1; bus_b.i_level_load = 1'b0;

        // Reset, then level 1 with run held high.
        repeat (3) cycle(1'b1, 1'b1, 1, 1'b0);
        cycle(1'b0, 1'b1, 1, 1'b0);
        check("reset_state",  64'(bus_a.o_state),  64'(0));
        check("reset_period", 64'(bus_a.o_period), 64'(BASE));
        check("reset_step",   64'(bus_a.o_step),   64'(0));
        repeat (95) cycle(1'b0, 1'b1, 1, 1'b0);

        // Level reloads, including level 0 and the clamped values.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, lv_tab[i], 1'b1);
            cycle(1'b0, 1'b1, lv_tab[i], 1'b0);
            check("load_state", 64'(bus_a.o_state), 64'(1));
            cycle(1'b0, 1'b1, lv_tab[i], 1'b0);
            check("load_period", 64'(bus_a.o_period), 64'(p_tab[i]));
            check("run_state",   64'(bus_a.o_state),  64'(2));
            repeat (2 * p_tab[i] + 3) cycle(1'b0, 1'b1, lv_tab[i], 1'b0);
        end

        // Level 1, then a 5-cycle pause mid-period.
        cycle(1'b0, 1'b1, 1, 1'b1);
        repeat (8) cycle(1'b0, 1'b1, 1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1, 1'b0);
        check("pause_state", 64'(bus_a.o_state), 64'(3));
        repeat (90) cycle(1'b0, 1'b1, 1, 1'b0);

        // Reload and pause in the same cycle as a due tick.
        for (int i = 0; i < 100; i++) begin
            if (m_state == M_RUN && m_phase == m_period - 1) break;
            cycle(1'b0, 1'b1, 1, 1'b0);
        end
        cycle(1'b0, 1'b0, 3, 1'b1);
        cycle(1'b0, 1'b0, 3, 1'b0);
        check("drop_tick_step", 64'(bus_a.o_step), 64'(0));
        check("drop_load",      64'(bus_a.o_state), 64'(1));
        cycle(1'b0, 1'b0, 3, 1'b0);
        check("drop_pause",  64'(bus_a.o_state),  64'(3));
        check("drop_period", 64'(bus_a.o_period), 64'(12));
        repeat (3) cycle(1'b0, 1'b0, 3, 1'b0);
        repeat (40) cycle(1'b0, 1'b1, 3, 1'b0);

        // Reset asserted in the cycle whose tick would raise a strobe.
        for (int i = 0; i < 100; i++) begin
            if (m_state == M_RUN && m_phase == m_period - 1) break;
            cycle(1'b0, 1'b1, 3, 1'b0);
        end
        cycle(1'b1, 1'b1, 3, 1'b0);
        cycle(1'b0, 1'b1, 1, 1'b0);
        check("rst_run_step",   64'({bus_a.o_step, bus_b.o_step}), 64'(0));
        check("rst_run_state",  64'(bus_a.o_state),  64'(0));
        check("rst_run_period", 64'(bus_a.o_period), 64'(BASE));
        repeat (60) cycle(1'b0, 1'b1, 1, 1'b0);

        // Randomised run/pause/reload/reset traffic.
        lvl = 1;
        for (int i = 0; i < 1200; i++) begin
            r     = int'($urandom_range(0, 99));
            run_r = (r < 85);
            ld_r  = ($urandom_range(0, 39) == 0);
            rst_r = ($urandom_range(0, 399) == 0);
            if (ld_r) begin
                if ($urandom_range(0, 3) == 0)
                    lvl = ($urandom_range(0, 1) == 0) ? 0 : 127;
                else
                    lvl = int'($urandom_range(1, 15));
            end
            cycle(rst_r, run_r, lvl, ld_r);
        end

        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        check("scoreboard_drain", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
